// File: rtl/piso_tx_pkg.sv
// Shared state encoding and sizing helper for the parallel-in serial-out transmitter.
package piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Frame bit counter: clear has priority over enable; the count saturates at LIMIT-1
// and tc is a registered flag that is high while the count sits on LIMIT-1.
module tx_bit_counter
  import piso_tx_pkg::*;
#(
  parameter int LIMIT = 8,
  parameter int CNT_W = cnt_width(LIMIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
    tc_d = (count_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock, with back-to-back frames chained on the last bit.
module piso_shift_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  output logic                     ser_out,
  output logic                     ser_out_n,
  output logic                     ser_valid,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int CNT_W = cnt_width(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("piso_shift_tx: WIDTH must be within 2..32");
  end

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;

  // Ready only when idle or on the final bit, so a new word can chain with no gap.
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    frame_start_d = accept;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sr_d    = load_data;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        if (last_bit) begin
          cnt_clr = 1'b1;
          if (accept) begin
            sr_d = load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero fill empties the register by the end of a frame, so ser_out idles at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      frame_start_q <= frame_start_d;
    end
  end

  tx_bit_counter #(
    .LIMIT (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (bit_cnt),
    .tc    (last_bit)
  );

  assign ser_out     = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign ser_out_n   = ~ser_out;
  assign ser_valid   = (state_q == SHIFT);
  assign frame_start = frame_start_q;
  assign frame_done  = last_bit;
  assign bit_idx     = bit_cnt;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a frame-level reference model.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;

  logic       rdy_m, so_m, son_m, sv_m, fs_m, fd_m;
  logic [2:0] idx_m;
  logic       rdy_l, so_l, son_l, sv_l, fs_l, fd_l;
  logic [2:0] idx_l;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_m), .ser_out(so_m), .ser_out_n(son_m), .ser_valid(sv_m),
    .frame_start(fs_m), .frame_done(fd_m), .bit_idx(idx_m)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_l), .ser_out(so_l), .ser_out_n(son_l), .ser_valid(sv_l),
    .frame_start(fs_l), .frame_done(fd_l), .bit_idx(idx_l)
  );

  always #5 clk = ~clk;

  // {ser_out, ser_out_n, ser_valid, frame_start, frame_done, bit_idx[2:0], load_ready}
  wire [8:0] got_m = {so_m, son_m, sv_m, fs_m, fd_m, idx_m, rdy_m};
  wire [8:0] got_l = {so_l, son_l, sv_l, fs_l, fd_l, idx_l, rdy_l};

  int errors = 0;
  int checks = 0;

  // Reference model: which frame bit is on the line, not how it gets there.
  bit         in_frame;
  int         idx;
  logic [7:0] word;
  bit         started;
  logic [8:0] exp_m, exp_l;

  task automatic model_out();
    logic b_m, b_l, done, rdy;
    b_m   = in_frame ? word[7 - idx] : 1'b0;
    b_l   = in_frame ? word[idx] : 1'b0;
    done  = in_frame && (idx == 7);
    rdy   = !in_frame || (idx == 7);
    exp_m = {b_m, ~b_m, in_frame, started, done, 3'(idx), rdy};
    exp_l = {b_l, ~b_l, in_frame, started, done, 3'(idx), rdy};
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    idx      = 0;
    word     = '0;
    started  = 1'b0;
    model_out();
  endtask

  // One clock: present inputs, advance the model at the edge, settle 1 ns after it.
  task automatic step(input bit lv, input logic [7:0] ld);
    bit acc;
    load_valid = lv;
    load_data  = ld;
    acc = lv && (!in_frame || idx == 7);
    @(posedge clk);
    if (acc) begin
      in_frame = 1'b1;
      idx      = 0;
      word     = ld;
    end else if (in_frame) begin
      if (idx == 7) begin
        in_frame = 1'b0;
        idx      = 0;
      end else begin
        idx++;
      end
    end
    started = acc;
    model_out();
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if ({so_m, son_m, sv_m, fd_m, rdy_m} !== 5'b01001) begin
        errors++;
        $display("FAIL reset_msb cyc%0d: got %b want 01001", i, {so_m, son_m, sv_m, fd_m, rdy_m});
      end
      checks++;
      if ({so_l, son_l, sv_l, fd_l, rdy_l} !== 5'b01001) begin
        errors++;
        $display("FAIL reset_lsb cyc%0d: got %b want 01001", i, {so_l, son_l, sv_l, fd_l, rdy_l});
      end
      checks++;
    end
    load_valid = 1'b0;
    #3 reset = 1'b0;
    model_reset();
    #1;
    if (got_m !== exp_m || got_l !== exp_l) begin
      errors++;
      $display("FAIL reset_release: got %b/%b want %b/%b", got_m, got_l, exp_m, exp_l);
    end
    checks++;
  endtask

  task automatic test_frame_a5();
    logic [7:0] rx_m, rx_l;
    rx_m = '0;
    rx_l = '0;
    for (int i = 0; i < 10; i++) begin
      step(i == 0, (i == 0) ? 8'hA5 : 8'h00);
      if (got_m !== exp_m || got_l !== exp_l) begin
        errors++;
        $display("FAIL frame_a5 cyc%0d: got %b/%b want %b/%b", i, got_m, got_l, exp_m, exp_l);
      end
      checks++;
      if (i < 8) begin
        rx_m = {rx_m[6:0], so_m};
        rx_l = {so_l, rx_l[7:1]};
      end
    end
    if (rx_m !== 8'hA5 || rx_l !== 8'hA5) begin
      errors++;
      $display("FAIL frame_a5_word: got %h/%h want a5/a5", rx_m, rx_l);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int sv_count;
    logic [15:0] rx_m;
    sv_count = 0;
    rx_m     = '0;
    for (int i = 0; i < 18; i++) begin
      if (i == 0)      step(1'b1, 8'hA5);
      else if (i < 9)  step(1'b1, 8'h3C);
      else             step(1'b0, 8'h00);
      if (got_m !== exp_m || got_l !== exp_l) begin
        errors++;
        $display("FAIL b2b cyc%0d: got %b/%b want %b/%b", i, got_m, got_l, exp_m, exp_l);
      end
      checks++;
      if (sv_m) begin
        sv_count++;
        rx_m = {rx_m[14:0], so_m};
      end
    end
    if (sv_count != 16 || rx_m !== 16'hA53C) begin
      errors++;
      $display("FAIL b2b_stream: got %0d bits %h want 16 bits a53c", sv_count, rx_m);
    end
    checks++;
  endtask

  task automatic test_busy_ignore();
    logic [7:0] rx_m;
    rx_m = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      step(1'b1, 8'h5A);
      else if (i == 4) step(1'b1, 8'hFF);
      else             step(1'b0, 8'h00);
      if (i == 3 && idx_m !== 3'd3) begin
        errors++;
        $display("FAIL busy_idx: got %0d want 3", idx_m);
      end
      if (i == 3) checks++;
      if (got_m !== exp_m || got_l !== exp_l) begin
        errors++;
        $display("FAIL busy cyc%0d: got %b/%b want %b/%b", i, got_m, got_l, exp_m, exp_l);
      end
      checks++;
      if (i < 8) rx_m = {rx_m[6:0], so_m};
    end
    if (rx_m !== 8'h5A || sv_m !== 1'b0) begin
      errors++;
      $display("FAIL busy_word: got %h valid %b want 5a valid 0", rx_m, sv_m);
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx_m;
    step(1'b1, 8'hC3);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    if (got_m !== exp_m || idx_m !== 3'd4) begin
      errors++;
      $display("FAIL midrst_pre: got %b idx %0d want %b idx 4", got_m, idx_m, exp_m);
    end
    checks++;
    #3 reset = 1'b1;
    #1;
    if (got_m !== 9'b0_1_0_0_0_000_1 || got_l !== 9'b0_1_0_0_0_000_1) begin
      errors++;
      $display("FAIL midrst_async: got %b/%b want 010000001", got_m, got_l);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (fd_m !== 1'b0 || sv_m !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold cyc%0d: done %b valid %b want 0 0", i, fd_m, sv_m);
      end
      checks++;
    end
    #3 reset = 1'b0;
    model_reset();
    rx_m = '0;
    for (int i = 0; i < 9; i++) begin
      step(i == 0, (i == 0) ? 8'h81 : 8'h00);
      if (got_m !== exp_m || got_l !== exp_l) begin
        errors++;
        $display("FAIL midrst_after cyc%0d: got %b/%b want %b/%b", i, got_m, got_l, exp_m, exp_l);
      end
      checks++;
      if (i < 8) rx_m = {rx_m[6:0], so_m};
    end
    if (rx_m !== 8'h81) begin
      errors++;
      $display("FAIL midrst_word: got %h want 81", rx_m);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom));
      if (got_m !== exp_m || got_l !== exp_l) begin
        errors++;
        $display("FAIL random cyc%0d: got %b/%b want %b/%b", i, got_m, got_l, exp_m, exp_l);
      end
      checks++;
    end
  endtask

  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    reset      = 1'b1;
    model_reset();
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
